// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared sizing helpers, saturation constants and parameter legality
// checks for the add_pipe pipelined adder (saturation enabled by ADD_PIPE_SAT_EN).
package add_pipe_pkg;

  localparam int MAX_W = 1024;

  function automatic int add_pipe_cw(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic logic [MAX_W-1:0] add_pipe_sat_max(input int width);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] add_pipe_sat_min(input int width);
    logic [MAX_W-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

  function automatic bit add_pipe_params_ok(input int width, input int lanes, input int stages);
    return (stages >= 1) && (stages <= 8) && (lanes >= 1) && (width >= 1) &&
           (width <= MAX_W) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/add_pipe_if.sv
// add_pipe_if: operand beat in, result beat out, for every lane of add_pipe.
interface add_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
);
  // A beat on a/b/sub is taken on every ce-high rising edge with in_vld=1 (no ready,
  // no backpressure); c/c_ovf hold a new result while c_vld=1 in a ce-high cycle.
  logic                   in_vld;
  logic                   sub;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [LANES*WIDTH-1:0] c;
  logic                   c_vld;
  logic [LANES-1:0]       c_ovf;

  modport master (output in_vld, sub, a, b, input c, c_vld, c_ovf);
  modport slave  (input in_vld, sub, a, b, output c, c_vld, c_ovf);
endinterface

// File: rtl/add_pipe_lane.sv
// add_pipe_lane: one lane's carry-split add/sub chain with skew/deskew registers,
// signed overflow detect and, under ADD_PIPE_SAT_EN, output saturation.
module add_pipe_lane
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_last_vld,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_c,
  output logic             o_ovf
);
  localparam int CW = add_pipe_cw(WIDTH, STAGES);

  // Stage-k inputs: hi_* hold chunks k.. (chunk k at bit 0), lo holds finished chunks.
  logic [WIDTH-1:0] w_hi_a [STAGES];
  logic [WIDTH-1:0] w_hi_b [STAGES];
  logic [WIDTH-1:0] w_lo   [STAGES];
  logic             w_cy   [STAGES];
  logic [WIDTH-1:0] w_res;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_ovf;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_c;
  logic             r_ovf;

  assign w_hi_a[0] = i_a;
  assign w_hi_b[0] = i_sub ? ~i_b : i_b;
  assign w_lo[0]   = '0;
  assign w_cy[0]   = i_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI_W = WIDTH - k * CW;
    logic [CW-1:0] w_sa;
    logic [CW-1:0] w_sb;
    assign w_sa = w_hi_a[k][CW-1:0];
    assign w_sb = w_hi_b[k][CW-1:0];

    if (k < STAGES - 1) begin : g_reg
      localparam int NH = HI_W - CW;
      localparam int NL = (k + 1) * CW;
      logic [CW:0]   w_sum;
      logic [NH-1:0] r_hi_a;
      logic [NH-1:0] r_hi_b;
      logic [NL-1:0] r_lo;
      logic          r_cy;

      assign w_sum = {1'b0, w_sa} + {1'b0, w_sb} + (CW+1)'(w_cy[k]);

      always_ff @(posedge i_clk) begin
        if (i_ce) begin
          r_hi_a <= w_hi_a[k][HI_W-1:CW];
          r_hi_b <= w_hi_b[k][HI_W-1:CW];
          r_lo   <= NL'(w_lo[k] | (WIDTH'(w_sum[CW-1:0]) << (k * CW)));
          r_cy   <= w_sum[CW];
        end
      end

      assign w_hi_a[k+1] = WIDTH'(r_hi_a);
      assign w_hi_b[k+1] = WIDTH'(r_hi_b);
      assign w_lo[k+1]   = WIDTH'(r_lo);
      assign w_cy[k+1]   = r_cy;
    end else begin : g_last
      // Top chunk: its carry-out is irrelevant, the operand signs live here.
      logic [CW-1:0] w_top;
      assign w_top   = w_sa + w_sb + CW'(w_cy[k]);
      assign w_res   = w_lo[k] | (WIDTH'(w_top) << (k * CW));
      assign w_sgn_a = w_sa[CW-1];
      assign w_sgn_b = w_sb[CW-1];
    end
  end

  assign w_ovf = (w_sgn_a == w_sgn_b) && (w_res[WIDTH-1] != w_sgn_a);

`ifdef ADD_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(add_pipe_sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(add_pipe_sat_min(WIDTH));
  assign w_out = !w_ovf ? w_res : (w_sgn_a ? SAT_MIN : SAT_MAX);
`else
  assign w_out = w_res;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c   <= '0;
      r_ovf <= 1'b0;
    end else if (i_ce && i_last_vld) begin
      r_c   <= w_out;
      r_ovf <= w_ovf;
    end
  end

  assign o_c   = r_c;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/add_pipe.sv
// add_pipe: multi-lane pipelined add/sub with valid tagging, overflow flags and
// hold-on-ce-low; define ADD_PIPE_SAT_EN to saturate overflowing lanes.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 1,
  parameter int STAGES = 1
) (
  input logic      ap_clk,
  input logic      ap_rst,
  input logic      ap_ce,
  add_pipe_if.slave bus
);
  if (!add_pipe_params_ok(WIDTH, LANES, STAGES)) begin : g_bad_params
    $error("add_pipe: illegal WIDTH/LANES/STAGES combination");
  end

  logic w_last_vld;
  logic r_c_vld;

  // Valid bit of the beat currently in the last (combinational) stage.
  if (STAGES == 1) begin : g_vld_one
    assign w_last_vld = bus.in_vld;
  end else begin : g_vld_chain
    logic [STAGES-2:0] r_vld;
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        r_vld <= '0;
      end else if (ap_ce) begin
        r_vld <= (STAGES-1)'({r_vld, bus.in_vld});
      end
    end
    assign w_last_vld = r_vld[STAGES-2];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_c_vld <= 1'b0;
    end else if (ap_ce) begin
      r_c_vld <= w_last_vld;
    end
  end

  assign bus.c_vld = r_c_vld;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add_pipe_lane #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
    ) u_lane (
      .i_clk      (ap_clk),
      .i_rst      (ap_rst),
      .i_ce       (ap_ce),
      .i_last_vld (w_last_vld),
      .i_sub      (bus.sub),
      .i_a        (bus.a[i*WIDTH +: WIDTH]),
      .i_b        (bus.b[i*WIDTH +: WIDTH]),
      .o_c        (bus.c[i*WIDTH +: WIDTH]),
      .o_ovf      (bus.c_ovf[i])
    );
  end
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: vector table, scoreboard and hand sequences for add_pipe
// (WIDTH=32 LANES=2 STAGES=4, plus a STAGES=1 LANES=1 instance); honours ADD_PIPE_SAT_EN.
module tb_add_pipe;
  localparam int WIDTH  = 32;
  localparam int LANES  = 2;
  localparam int STAGES = 4;
  localparam int SB_W   = 32 + 2 + 64;

`ifdef ADD_PIPE_SAT_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
`endif

  typedef struct {
    logic        sb;
    logic [31:0] a0, b0, a1, b1;
    logic [31:0] c0, c1;
    logic [1:0]  ovf;
  } vec_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ap_ce  = 1'b0;
  logic ce1    = 1'b0;

  int total = 0;
  int bad   = 0;
  int ce_edges = 0;
  int run = 0;
  int max_run = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_e;
  vec_t tbl [8];

  add_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();
  add_pipe_if #(.WIDTH(WIDTH), .LANES(1))     bus1 ();

  add_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .ap_ce  (ap_ce),
    .bus    (bus.slave)
  );

  add_pipe #(.WIDTH(WIDTH), .LANES(1), .STAGES(1)) dut1 (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .ap_ce  (ce1),
    .bus    (bus1.slave)
  );

  // clock / reset-free housekeeping
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) if (ap_ce && !ap_rst) ce_edges++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic sb, input logic [31:0] x, input logic [31:0] y);
    longint r;
    logic ovf;
    logic [31:0] v;
    r = sb ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
    ovf = !((&r[63:31]) || !(|r[63:31]));
    v = r[31:0];
`ifdef ADD_PIPE_SAT_EN
    if (ovf) v = r[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ovf, v};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic vld, input logic sb,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    ap_ce      = ce;
    bus.in_vld = vld;
    bus.sub    = sb;
    bus.a      = {a1, a0};
    bus.b      = {b1, b0};
  endtask

  task automatic push(input logic [63:0] c, input logic [1:0] ovf);
    exp_q.push_back({32'(ce_edges + STAGES), ovf, c});
  endtask

  task automatic beat(input logic ce, input logic vld, input logic sb,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1);
    logic [32:0] m0, m1;
    drive(ce, vld, sb, a0, b0, a1, b1);
    if (ce && vld && !ap_rst) begin
      m0 = model(sb, a0, b0);
      m1 = model(sb, a1, b1);
      push({m1[31:0], m0[31:0]}, {m1[32], m0[32]});
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // scoreboard: consume one result per ce-high cycle with c_vld
  always @(negedge ap_clk) begin
    if (!ap_rst && ap_ce) begin
      if (bus.c_vld) begin
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got c=%0h want no beat", bus.c);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_c", bus.c, mon_e[63:0]);
          check("sb_ovf", 64'(bus.c_ovf), 64'(mon_e[65:64]));
          check("sb_latency", 64'(ce_edges), 64'(mon_e[97:66]));
        end
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    int n;
    tbl[0] = '{sb:1'b0, a0:32'hFFFF_FFFF, b0:32'h0000_0001, a1:32'h0, b1:32'h0,
               c0:32'h0000_0000, c1:32'h0000_0000, ovf:2'b00};
    tbl[1] = '{sb:1'b0, a0:32'h7FFF_FFFF, b0:32'h0000_0001, a1:32'h5, b1:32'hFFFF_FFF9,
               c0:POS_OVF, c1:32'hFFFF_FFFE, ovf:2'b01};
    tbl[2] = '{sb:1'b1, a0:32'h8000_0000, b0:32'h0000_0001, a1:32'h5, b1:32'h7,
               c0:NEG_OVF, c1:32'hFFFF_FFFE, ovf:2'b01};
    tbl[3] = '{sb:1'b0, a0:32'h8000_0000, b0:32'hFFFF_FFFF, a1:32'h4000_0000, b1:32'h4000_0000,
               c0:NEG_OVF, c1:POS_OVF, ovf:2'b11};
    tbl[4] = '{sb:1'b1, a0:32'h0, b0:32'h8000_0000, a1:32'h1234_5678, b1:32'h1234_5678,
               c0:POS_OVF, c1:32'h0, ovf:2'b01};
    tbl[5] = '{sb:1'b1, a0:32'd10, b0:32'd3, a1:32'h0, b1:32'h1,
               c0:32'd7, c1:32'hFFFF_FFFF, ovf:2'b00};
    tbl[6] = '{sb:1'b0, a0:32'h0000_FFFF, b0:32'h1, a1:32'h00FF_00FF, b1:32'h00FF_0001,
               c0:32'h0001_0000, c1:32'h01FE_0100, ovf:2'b00};
    tbl[7] = '{sb:1'b1, a0:32'h7FFF_FFFF, b0:32'hFFFF_FFFF, a1:32'hFFFF_FFFF, b1:32'h8000_0000,
               c0:POS_OVF, c1:32'h7FFF_FFFF, ovf:2'b01};

    // reset: two cycles, both instances
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus1.in_vld = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
    ap_rst = 1'b1;
    tick(); tick();
    check("rst_c", bus.c, 64'h0);
    check("rst_vld", 64'(bus.c_vld), 64'h0);
    check("rst_ovf", 64'(bus.c_ovf), 64'h0);
    check("rst1_c", 64'(bus1.c), 64'h0);
    check("rst1_vld", 64'(bus1.c_vld), 64'h0);
    ap_rst = 1'b0;
    idle(2);

    // carry ripple with explicit latency count
    drive(1'b1, 1'b1, tbl[0].sb, tbl[0].a0, tbl[0].b0, tbl[0].a1, tbl[0].b1);
    push({tbl[0].c1, tbl[0].c0}, tbl[0].ovf);
    tick();
    n = 0;
    while (!bus.c_vld && n < 10) begin
      idle(1);
      n++;
    end
    check("ripple_latency", 64'(n), 64'(STAGES - 1));
    idle(3);

    // vector table, back to back
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b1, tbl[i].sb, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      push({tbl[i].c1, tbl[i].c0}, tbl[i].ovf);
      tick();
    end
    idle(STAGES + 2);

    // streaming: 8 back-to-back beats, lane0 a=b=n
    run = 0; max_run = 0;
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b1, 1'b0, 32'(i), 32'(i), $urandom, $urandom);
    idle(STAGES + 4);
    check("stream_run", 64'(max_run), 64'd8);

    // stall: 3 beats in flight, ce low for 3 cycles, junk beat offered meanwhile
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b0, 32'(100 + i), 32'(i), 32'(i), 32'd1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b1, 1'b0, 32'hDEAD_0000, 32'h1, 32'h1, 32'h1);
      check("stall_vld_low", 64'(bus.c_vld), 64'h0);
    end
    idle(1);
    check("stall_first_vld", 64'(bus.c_vld), 64'h1);
    check("stall_first_c", 64'(bus.c[31:0]), 64'd100);
    for (int i = 0; i < 2; i++) begin
      beat(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check("hold_vld", 64'(bus.c_vld), 64'h1);
      check("hold_c", 64'(bus.c[31:0]), 64'd100);
    end
    idle(STAGES + 2);

    // reset with beats in flight and ce low
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b1, 32'h55, 32'(i), 32'h9, 32'h2);
    ap_rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h1, 32'h1, 32'h1, 32'h1);
    tick(); tick();
    exp_q.delete();
    check("midrst_c", bus.c, 64'h0);
    check("midrst_vld", 64'(bus.c_vld), 64'h0);
    check("midrst_ovf", 64'(bus.c_ovf), 64'h0);
    ap_rst = 1'b0;
    idle(STAGES + 4);

    // random traffic with random ce
    for (int i = 0; i < 80; i++) begin
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           pick(), pick(), pick(), pick());
    end
    idle(STAGES + 4);
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    // single-stage, single-lane instance
    ce1 = 1'b1;
    bus1.in_vld = 1'b1; bus1.sub = 1'b0; bus1.a = 32'd3; bus1.b = 32'd4;
    tick();
    check("s1_add_c", 64'(bus1.c), 64'd7);
    check("s1_add_vld", 64'(bus1.c_vld), 64'h1);
    check("s1_add_ovf", 64'(bus1.c_ovf), 64'h0);
    bus1.sub = 1'b1;
    tick();
    check("s1_sub_c", 64'(bus1.c), 64'hFFFF_FFFF);
    bus1.in_vld = 1'b0;
    tick();
    check("s1_idle_vld", 64'(bus1.c_vld), 64'h0);
    check("s1_idle_hold", 64'(bus1.c), 64'hFFFF_FFFF);
    bus1.in_vld = 1'b1; bus1.sub = 1'b0; bus1.a = 32'h7FFF_FFFF; bus1.b = 32'h1;
    tick();
    check("s1_ovf_c", 64'(bus1.c), 64'(POS_OVF));
    check("s1_ovf_flag", 64'(bus1.c_ovf), 64'h1);
    bus1.in_vld = 1'b0;
    ce1 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
